// File: rtl/led_share_arbiter.sv
// Round-robin owner of the 8 front-panel LEDs with per-owner dwell, blanking gap
// and optional urgent pre-emption by source 0. Optional heartbeat: LED_SHARE_HEARTBEAT_EN.
`timescale 1ns/1ps
module led_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DWELL_W    = 24,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_led,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 urgent_en,
    output logic [7:0]           led,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [7:0]           led_q, led_d;
    logic                 busy_q, busy_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

    logic [7:0]           idle_led;
    logic [DWELL_W-1:0]   dwell_load;
    logic [7:0]           owner_led;
    logic                 owner_req;
    logic                 others_req;
    logic                 preempt;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     scan_idx;
    logic [IDX_W-1:0]     next_ptr;
    int                   scan_j;

`ifdef LED_SHARE_HEARTBEAT_EN
    logic [22:0] hb_cnt_q, hb_cnt_d;

    always_comb begin
        hb_cnt_d = hb_cnt_q + 23'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
        end
    end

    assign idle_led = {7'b0, hb_cnt_q[22]};
`else
    assign idle_led = 8'h00;
`endif

    // A zero dwell is treated as one cycle so the owner can never lock up.
    assign dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign owner_led  = req_led[{owner_q, 3'b000} +: 8];
    assign owner_req  = req[owner_q];
    assign others_req = |(req & ~grant_q);
    assign next_ptr   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    assign preempt    = urgent_en && req[0] &&
                        ((state_q == ST_GAP) || ((state_q == ST_SHOW) && (owner_q != '0)));

    // First requester at or above rr_ptr, wrapping round to the bottom.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        scan_j    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_j = int'(rr_ptr_q) + i;
            if (scan_j >= NUM_REQ) begin
                scan_j = scan_j - NUM_REQ;
            end
            scan_idx = IDX_W'(scan_j);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        led_d       = 8'h00;
        dwell_cnt_d = dwell_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                led_d   = idle_led;
                if (win_found) begin
                    state_d          = ST_SHOW;
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    dwell_cnt_d      = dwell_load;
                    led_d            = 8'h00;
                end
            end
            ST_SHOW: begin
                led_d       = owner_led;
                dwell_cnt_d = (dwell_cnt_q != '0) ? dwell_cnt_q - DWELL_W'(1) : '0;
                if (!owner_req || ((dwell_cnt_q <= DWELL_W'(1)) && others_req)) begin
                    grant_d  = '0;
                    led_d    = 8'h00;
                    rr_ptr_d = next_ptr;
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_W'(GAP_CYCLES);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (dwell_cnt_q <= DWELL_W'(1)) begin
                    dwell_cnt_d = dwell_load;
                end
            end
            ST_GAP: begin
                grant_d   = '0;
                gap_cnt_d = (gap_cnt_q != '0) ? gap_cnt_q - GAP_W'(1) : '0;
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        // Urgent source 0 overrides every other transition; round-robin order is left alone.
        if (preempt) begin
            state_d     = ST_SHOW;
            owner_d     = '0;
            grant_d     = '0;
            grant_d[0]  = 1'b1;
            dwell_cnt_d = dwell_load;
            led_d       = req_led[7:0];
            rr_ptr_d    = rr_ptr_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            led_q       <= 8'h00;
            busy_q      <= 1'b0;
            dwell_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            dwell_cnt_q <= dwell_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign led   = led_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter: reset, single source, round robin,
// early release, urgent pre-emption and zero dwell.
`timescale 1ns/1ps
module tb_led_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_led = '0;
    logic [23:0] dwell = '0;
    logic        urgent_en = 1'b0;
    logic [7:0]  led;
    logic [3:0]  grant;
    logic        busy;

    int checks = 0;
    int failures = 0;

    led_share_arbiter #(
        .NUM_REQ    (4),
        .DWELL_W    (24),
        .GAP_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_led   (req_led),
        .dwell     (dwell),
        .urgent_en (urgent_en),
        .led       (led),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req       = '0;
        urgent_en = 1'b0;
        rst_n     = 1'b0;
        #1;
        rst_n     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int held;
        logic led_ok;
        logic [3:0]  exp_g;
        logic [31:0] sl;

        req_led = {8'h44, 8'hA5, 8'h22, 8'h5A};
        repeat (2) tick();
        check("reset_led", 32'(led), 32'h00);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_grant", 32'(grant), 32'h0);

        // Single source 2, dwell 5
        req = 4'b0100;
        dwell = 24'd5;
        tick();
        check("single_grant", 32'(grant), 32'h4);
        check("single_busy", 32'(busy), 32'h1);
        check("single_led_first", 32'(led), 32'h00);
        tick();
        check("single_led", 32'(led), 32'hA5);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant == 4'b0100 && led == 8'hA5) held++;
        end
        check("single_held", 32'(held), 32'd20);
        req_led[23:16] = 8'h3C;
        tick();
        check("single_led_follow", 32'(led), 32'h3C);
        req_led[23:16] = 8'hA5;

        // Asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h00);
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        req = '0;
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'h0);

        // Round robin over all four sources
        req = 4'b1111;
        dwell = 24'd3;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            check("rr_grant", 32'(grant), 32'(exp_g));
            check("rr_led_first", 32'(led), 32'h00);
            if (k == 4) break;
            n = 1;
            tick();
            sl = req_led >> (8 * (k % 4));
            check("rr_led", 32'(led), 32'(sl[7:0]));
            while (grant == exp_g && n < 40) begin
                n++;
                tick();
            end
            check("rr_dwell_len", 32'(n), 32'd3);
            n = 0;
            led_ok = 1'b1;
            while (grant == 4'b0000 && n < 60) begin
                if (led != 8'h00) led_ok = 1'b0;
                n++;
                tick();
            end
            check("rr_gap_len", 32'(n), 32'd17);
            check("rr_gap_led", 32'(led_ok), 32'h1);
        end

        // Early release of owner 1 at dwell_cnt = 60
        do_reset();
        req = 4'b0010;
        dwell = 24'd100;
        tick();
        check("early_grant", 32'(grant), 32'h2);
        repeat (40) tick();
        check("early_still", 32'(grant), 32'h2);
        req = 4'b0000;
        tick();
        check("early_drop_grant", 32'(grant), 32'h0);
        check("early_drop_busy", 32'(busy), 32'h1);
        check("early_drop_led", 32'(led), 32'h00);
        req = 4'b0101;
        n = 0;
        while (grant == 4'b0000 && n < 60) begin
            n++;
            tick();
        end
        check("early_gap_len", 32'(n), 32'd17);
        check("early_rr_ptr", 32'(grant), 32'h4);

        // No pre-emption: source 0 waits out owner 3 and the gap
        do_reset();
        req = 4'b1000;
        dwell = 24'd4;
        tick();
        check("nopre_grant3", 32'(grant), 32'h8);
        req = 4'b1001;
        repeat (3) tick();
        check("nopre_hold3", 32'(grant), 32'h8);
        tick();
        check("nopre_gap", 32'(grant), 32'h0);
        n = 0;
        while (grant == 4'b0000 && n < 60) begin
            n++;
            tick();
        end
        check("nopre_gap_len", 32'(n), 32'd17);
        check("nopre_grant0", 32'(grant), 32'h1);

        // Owner 0 is not pre-empted by itself; pre-emption out of GAP
        urgent_en = 1'b1;
        repeat (3) tick();
        check("self_hold", 32'(grant), 32'h1);
        tick();
        check("self_leave_grant", 32'(grant), 32'h0);
        check("self_leave_busy", 32'(busy), 32'h1);
        tick();
        check("gap_pre_grant", 32'(grant), 32'h1);
        check("gap_pre_led", 32'(led), 32'h5A);

        // Pre-emption of owner 3 in SHOW
        do_reset();
        req = 4'b1000;
        dwell = 24'd100;
        tick();
        tick();
        check("pre_led3", 32'(led), 32'h44);
        urgent_en = 1'b1;
        req = 4'b1001;
        tick();
        check("pre_grant", 32'(grant), 32'h1);
        check("pre_led", 32'(led), 32'h5A);
        check("pre_busy", 32'(busy), 32'h1);

        // Zero dwell behaves as one cycle
        do_reset();
        req = 4'b0001;
        dwell = 24'd0;
        tick();
        check("dwell0_grant", 32'(grant), 32'h1);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant == 4'b0001 && busy) held++;
        end
        check("dwell0_held", 32'(held), 32'd10);
        check("dwell0_led", 32'(led), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
